// File: rtl/bus_arbiter_ctrl.sv
// Two-master / three-slave serial bus sequencer: arbitrates, captures the slave ID
// serially, connects the slave and holds until release. Optional: ARB_ROUND_ROBIN_EN.
module bus_arbiter_ctrl #(
    parameter int SLAVE_ID_W = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       m1_request,
    input  logic       m2_request,
    input  logic       m1_master_valid,
    input  logic       m2_master_valid,
    input  logic       m1_tx_address,
    input  logic       m2_tx_address,
    input  logic [2:0] slave_ready,
    output logic [1:0] bus_grant,
    output logic [2:0] slave_grant,
    output logic       bus_busy,
    output logic       arb_error
);

    localparam int          CNT_W    = $clog2(SLAVE_ID_W + 1);
    localparam logic [1:0]  GNT_NONE = 2'b00;
    localparam logic [1:0]  GNT_M1   = 2'b01;
    localparam logic [1:0]  GNT_M2   = 2'b10;
    localparam logic [15:0] TMO_LIM  = 16'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_CONN,
        S_REL
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            bus_grant_q, bus_grant_d;
    logic [2:0]            slave_grant_q, slave_grant_d;
    logic [2:0]            slave_sel_q, slave_sel_d;
    logic                  bus_busy_q, bus_busy_d;
    logic                  arb_error_q, arb_error_d;
    logic [SLAVE_ID_W-1:0] id_q, id_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [15:0]           tmo_cnt_q, tmo_cnt_d;

    logic                  g_req, g_valid, g_bit;
    logic [SLAVE_ID_W-1:0] id_shift;
    logic [15:0]           tmo_next;
    logic                  dec_ok;
    logic [2:0]            dec_sel;
    logic                  win_m2;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_m2_q, last_m2_d;
`endif

    // Maps the captured ID to a one-hot slave select; returns {valid, one_hot}.
    function automatic logic [3:0] decode_id(input logic [SLAVE_ID_W-1:0] id);
        logic [31:0] v;
        v = 32'(id);
        case (v)
            32'd0:   decode_id = 4'b1_001;
            32'd1:   decode_id = 4'b1_010;
            32'd2:   decode_id = 4'b1_100;
            default: decode_id = 4'b0_000;
        endcase
    endfunction

    always_comb begin
        g_req    = bus_grant_q[1] ? m2_request      : m1_request;
        g_valid  = bus_grant_q[1] ? m2_master_valid : m1_master_valid;
        g_bit    = bus_grant_q[1] ? m2_tx_address   : m1_tx_address;
        id_shift = (id_q << 1) | SLAVE_ID_W'(g_bit);
        tmo_next = tmo_cnt_q + 16'd1;
        {dec_ok, dec_sel} = decode_id(id_shift);
`ifdef ARB_ROUND_ROBIN_EN
        win_m2 = m2_request && (!m1_request || !last_m2_q);
`else
        win_m2 = m2_request && !m1_request;
`endif
    end

    always_comb begin
        // NOTE: every signal gets its default first so no branch can infer a latch.
        state_d       = state_q;
        bus_grant_d   = bus_grant_q;
        slave_grant_d = slave_grant_q;
        slave_sel_d   = slave_sel_q;
        arb_error_d   = 1'b0;
        id_d          = id_q;
        bit_cnt_d     = bit_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_m2_d     = last_m2_q;
`endif

        case (state_q)
            S_IDLE: begin
                bus_grant_d   = GNT_NONE;
                slave_grant_d = 3'b000;
                slave_sel_d   = 3'b000;
                id_d          = '0;
                bit_cnt_d     = '0;
                tmo_cnt_d     = '0;
                if (m1_request || m2_request) begin
                    state_d     = S_ADDR;
                    bus_grant_d = win_m2 ? GNT_M2 : GNT_M1;
                end
            end

            S_ADDR: begin
                tmo_cnt_d = tmo_next;
                if (!g_req) begin
                    state_d     = S_IDLE;
                    bus_grant_d = GNT_NONE;
                end else if (tmo_next == TMO_LIM) begin
                    state_d     = S_IDLE;
                    bus_grant_d = GNT_NONE;
                    arb_error_d = 1'b1;
                end else if (g_valid) begin
                    id_d      = id_shift;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(SLAVE_ID_W - 1)) begin
                        if (dec_ok) begin
                            state_d     = S_WAIT;
                            slave_sel_d = dec_sel;
                        end else begin
                            state_d     = S_IDLE;
                            bus_grant_d = GNT_NONE;
                            arb_error_d = 1'b1;
                        end
                    end
                end
            end

            S_WAIT: begin
                tmo_cnt_d = tmo_next;
                // A ready slave beats a simultaneous timeout.
                if (!g_req) begin
                    state_d     = S_IDLE;
                    bus_grant_d = GNT_NONE;
                end else if ((slave_ready & slave_sel_q) != 3'b000) begin
                    state_d       = S_CONN;
                    slave_grant_d = slave_sel_q;
`ifdef ARB_ROUND_ROBIN_EN
                    last_m2_d     = bus_grant_q[1];
`endif
                end else if (tmo_next == TMO_LIM) begin
                    state_d     = S_IDLE;
                    bus_grant_d = GNT_NONE;
                    arb_error_d = 1'b1;
                end
            end

            S_CONN: begin
                if (!g_req) begin
                    state_d       = S_REL;
                    bus_grant_d   = GNT_NONE;
                    slave_grant_d = 3'b000;
                end
            end

            S_REL: begin
                state_d       = S_IDLE;
                bus_grant_d   = GNT_NONE;
                slave_grant_d = 3'b000;
            end

            default: begin
                state_d       = S_IDLE;
                bus_grant_d   = GNT_NONE;
                slave_grant_d = 3'b000;
            end
        endcase

        bus_busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= S_IDLE;
            bus_grant_q   <= GNT_NONE;
            slave_grant_q <= 3'b000;
            slave_sel_q   <= 3'b000;
            bus_busy_q    <= 1'b0;
            arb_error_q   <= 1'b0;
            id_q          <= '0;
            bit_cnt_q     <= '0;
            tmo_cnt_q     <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values together.
            state_q       <= state_d;
            bus_grant_q   <= bus_grant_d;
            slave_grant_q <= slave_grant_d;
            slave_sel_q   <= slave_sel_d;
            bus_busy_q    <= bus_busy_d;
            arb_error_q   <= arb_error_d;
            id_q          <= id_d;
            bit_cnt_q     <= bit_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Reset to m2 so the first contested grant goes to m1.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_m2_q <= 1'b1;
        end else begin
            last_m2_q <= last_m2_d;
        end
    end
`endif

    assign bus_grant   = bus_grant_q;
    assign slave_grant = slave_grant_q;
    assign bus_busy    = bus_busy_q;
    assign arb_error   = arb_error_q;

endmodule

// File: tb/tb_bus_arbiter_ctrl.sv
// Directed bench for bus_arbiter_ctrl; outputs are sampled on the falling edge as
// {bus_grant, slave_grant, bus_busy, arb_error}.
module tb_bus_arbiter_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic       m1_request, m2_request;
    logic       m1_master_valid, m2_master_valid;
    logic       m1_tx_address, m2_tx_address;
    logic [2:0] slave_ready;
    logic [1:0] bus_grant;
    logic [2:0] slave_grant;
    logic       bus_busy;
    logic       arb_error;
    logic [6:0] outs;

    int n_checks = 0;
    int n_fail   = 0;

    assign outs = {bus_grant, slave_grant, bus_busy, arb_error};

    always #5 clk = ~clk;

    bus_arbiter_ctrl #(
        .SLAVE_ID_W (2),
        .TIMEOUT    (8)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .m1_request      (m1_request),
        .m2_request      (m2_request),
        .m1_master_valid (m1_master_valid),
        .m2_master_valid (m2_master_valid),
        .m1_tx_address   (m1_tx_address),
        .m2_tx_address   (m2_tx_address),
        .slave_ready     (slave_ready),
        .bus_grant       (bus_grant),
        .slave_grant     (slave_grant),
        .bus_busy        (bus_busy),
        .arb_error       (arb_error)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive_bit(input logic use_m2, input logic b);
        if (use_m2) begin
            m2_master_valid = 1'b1;
            m2_tx_address   = b;
        end else begin
            m1_master_valid = 1'b1;
            m1_tx_address   = b;
        end
        tick();
        m1_master_valid = 1'b0;
        m2_master_valid = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        m1_request = 0; m2_request = 0;
        m1_master_valid = 0; m2_master_valid = 0;
        m1_tx_address = 0; m2_tx_address = 0;
        slave_ready = 3'b000;
        tick();
        n_checks++;
        if (outs !== 7'b00_000_0_0) begin
            n_fail++; $display("FAIL reset_outputs: got %b expected %b", outs, 7'b00_000_0_0);
        end
        rstn = 1'b1;
        tick();
        n_checks++;
        if (outs !== 7'b00_000_0_0) begin
            n_fail++; $display("FAIL idle_after_reset: got %b expected %b", outs, 7'b00_000_0_0);
        end
    endtask

    task automatic test_basic_grant();
        m1_request = 1'b1;
        tick();
        n_checks++;
        if (outs !== 7'b01_000_1_0) begin
            n_fail++; $display("FAIL basic_grant: got %b expected %b", outs, 7'b01_000_1_0);
        end
        drive_bit(1'b0, 1'b1);
        tick();                         // invalid cycle, must be ignored
        drive_bit(1'b0, 1'b0);          // ID = 2 -> slave 3
        n_checks++;
        if (outs !== 7'b01_000_1_0) begin
            n_fail++; $display("FAIL basic_wait: got %b expected %b", outs, 7'b01_000_1_0);
        end
        slave_ready = 3'b111;
        tick();
        n_checks++;
        if (outs !== 7'b01_100_1_0) begin
            n_fail++; $display("FAIL basic_conn: got %b expected %b", outs, 7'b01_100_1_0);
        end
    endtask

    task automatic test_release();
        m2_request  = 1'b1;
        slave_ready = 3'b000;
        tick();
        tick();
        n_checks++;
        if (outs !== 7'b01_100_1_0) begin
            n_fail++; $display("FAIL conn_hold: got %b expected %b", outs, 7'b01_100_1_0);
        end
        m1_request = 1'b0;
        tick();
        n_checks++;
        if (outs !== 7'b00_000_1_0) begin
            n_fail++; $display("FAIL rel_state: got %b expected %b", outs, 7'b00_000_1_0);
        end
        tick();
        n_checks++;
        if (outs !== 7'b00_000_0_0) begin
            n_fail++; $display("FAIL rel_to_idle: got %b expected %b", outs, 7'b00_000_0_0);
        end
        tick();
        n_checks++;
        if (outs !== 7'b10_000_1_0) begin
            n_fail++; $display("FAIL pending_m2_grant: got %b expected %b", outs, 7'b10_000_1_0);
        end
    endtask

    task automatic test_invalid_id();
        drive_bit(1'b1, 1'b1);
        n_checks++;
        if (outs !== 7'b10_000_1_0) begin
            n_fail++; $display("FAIL invalid_first_bit: got %b expected %b", outs, 7'b10_000_1_0);
        end
        drive_bit(1'b1, 1'b1);
        n_checks++;
        if (outs !== 7'b00_000_0_1) begin
            n_fail++; $display("FAIL invalid_id_error: got %b expected %b", outs, 7'b00_000_0_1);
        end
        m2_request = 1'b0;
        tick();
        n_checks++;
        if (outs !== 7'b00_000_0_0) begin
            n_fail++; $display("FAIL error_one_cycle: got %b expected %b", outs, 7'b00_000_0_0);
        end
    endtask

    task automatic test_timeout();
        slave_ready = 3'b101;           // other slaves ready, target slave 2 is not
        m1_request  = 1'b1;
        tick();
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b1);          // ID = 1 -> slave 2
        for (int k = 3; k <= 7; k++) begin
            tick();
            n_checks++;
            if (outs !== 7'b01_000_1_0) begin
                n_fail++; $display("FAIL timeout_early_c%0d: got %b expected %b", k, outs, 7'b01_000_1_0);
            end
        end
        tick();
        n_checks++;
        if (outs !== 7'b00_000_0_1) begin
            n_fail++; $display("FAIL timeout_error: got %b expected %b", outs, 7'b00_000_0_1);
        end
        m1_request  = 1'b0;
        slave_ready = 3'b000;
        tick();
        n_checks++;
        if (outs !== 7'b00_000_0_0) begin
            n_fail++; $display("FAIL timeout_idle: got %b expected %b", outs, 7'b00_000_0_0);
        end
    endtask

    task automatic test_timeout_vs_ready();
        m1_request = 1'b1;
        tick();
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b0);          // ID = 0 -> slave 1
        for (int k = 3; k <= 7; k++) tick();
        slave_ready = 3'b001;           // arrives on the timeout cycle
        tick();
        n_checks++;
        if (outs !== 7'b01_001_1_0) begin
            n_fail++; $display("FAIL ready_beats_timeout: got %b expected %b", outs, 7'b01_001_1_0);
        end
        m1_request  = 1'b0;
        slave_ready = 3'b000;
        tick();
        tick();
        n_checks++;
        if (outs !== 7'b00_000_0_0) begin
            n_fail++; $display("FAIL ready_release_idle: got %b expected %b", outs, 7'b00_000_0_0);
        end
    endtask

    task automatic test_abort();
        m1_request = 1'b1;
        tick();
        drive_bit(1'b0, 1'b1);
        m1_request = 1'b0;
        drive_bit(1'b0, 1'b1);          // last bit of invalid ID, same cycle as drop
        n_checks++;
        if (outs !== 7'b00_000_0_0) begin
            n_fail++; $display("FAIL abort_beats_decode: got %b expected %b", outs, 7'b00_000_0_0);
        end
        m2_request = 1'b1;
        tick();
        n_checks++;
        if (outs !== 7'b10_000_1_0) begin
            n_fail++; $display("FAIL abort_m2_grant: got %b expected %b", outs, 7'b10_000_1_0);
        end
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b1, 1'b0);
        m2_request = 1'b0;
        tick();
        n_checks++;
        if (outs !== 7'b00_000_0_0) begin
            n_fail++; $display("FAIL abort_in_wait: got %b expected %b", outs, 7'b00_000_0_0);
        end
    endtask

    task automatic test_async_reset();
        m1_request  = 1'b1;
        slave_ready = 3'b111;
        tick();
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b1);
        tick();
        n_checks++;
        if (outs !== 7'b01_010_1_0) begin
            n_fail++; $display("FAIL areset_conn: got %b expected %b", outs, 7'b01_010_1_0);
        end
        #2 rstn = 1'b0;
        #1;
        n_checks++;
        if (outs !== 7'b00_000_0_0) begin
            n_fail++; $display("FAIL areset_immediate: got %b expected %b", outs, 7'b00_000_0_0);
        end
        m1_request  = 1'b0;
        slave_ready = 3'b000;
        tick();
        rstn = 1'b1;
        tick();
        n_checks++;
        if (outs !== 7'b00_000_0_0) begin
            n_fail++; $display("FAIL areset_idle: got %b expected %b", outs, 7'b00_000_0_0);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_gnt [3];
`ifdef ARB_ROUND_ROBIN_EN
        exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b01;
`else
        exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b01; exp_gnt[2] = 2'b01;
`endif
        m1_request  = 1'b1;
        m2_request  = 1'b1;
        slave_ready = 3'b111;
        for (int t = 0; t < 3; t++) begin
            tick();
            n_checks++;
            if (bus_grant !== exp_gnt[t]) begin
                n_fail++; $display("FAIL b2b_grant_%0d: got %b expected %b", t, bus_grant, exp_gnt[t]);
            end
            drive_bit(exp_gnt[t][1], 1'b0);
            drive_bit(exp_gnt[t][1], 1'b0);
            tick();
            n_checks++;
            if (outs !== {exp_gnt[t], 5'b001_1_0}) begin
                n_fail++; $display("FAIL b2b_conn_%0d: got %b expected %b", t, outs, {exp_gnt[t], 5'b001_1_0});
            end
            if (exp_gnt[t][1]) m2_request = 1'b0; else m1_request = 1'b0;
            tick();
            m1_request = 1'b1;
            m2_request = 1'b1;
            tick();
            n_checks++;
            if (outs !== 7'b00_000_0_0) begin
                n_fail++; $display("FAIL b2b_idle_%0d: got %b expected %b", t, outs, 7'b00_000_0_0);
            end
        end
        m1_request  = 1'b0;
        m2_request  = 1'b0;
        slave_ready = 3'b000;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_grant();
        test_release();
        test_invalid_id();
        test_timeout();
        test_timeout_vs_ready();
        test_abort();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
